// File: rtl/xor_fault_monitor.sv
// ---------------------------------------------------------------------------
// xor_fault_monitor
//
// Stimulus/checker wrapped around the XOR laser target. Sweeps every WIDTH-bit
// input vector repeatedly. Each vector is held for SETTLE_CYCLES cycles, then
// the synchronized target output is sampled once and compared with the
// expected parity. Mismatches (laser-induced faults) are counted and the most
// recent one is captured. In IDLE, `locate` drives the target's osc_en so its
// input toggles with the clock for photon-emission location.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             level, begins sweeping from IDLE
//   stop              finish the current vector, then return to IDLE
//   locate            in IDLE, drives dut_osc_en high (one-cycle latency)
//   clear             synchronous clear of counters, captures, vector register
//   dut_a, dut_osc_en drive the target
//   dut_q             target output, asynchronous to clk
//   busy              high in SETTLE or SAMPLE
//   fault_pulse       one-cycle pulse per detected mismatch
//   fault_count       saturating mismatch count
//   sweep_count       saturating count of completed full sweeps
//   last_fault_vec/q  dut_a and sampled q at the most recent mismatch
//   last_fault_valid  set on first mismatch since reset or clear
// ---------------------------------------------------------------------------
module xor_fault_monitor #(
    parameter int WIDTH         = 6,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             locate,
    input  logic             clear,
    output logic [WIDTH-1:0] dut_a,
    output logic             dut_osc_en,
    input  logic             dut_q,
    output logic             busy,
    output logic             fault_pulse,
    output logic [CNT_W-1:0] fault_count,
    output logic [CNT_W-1:0] sweep_count,
    output logic [WIDTH-1:0] last_fault_vec,
    output logic             last_fault_q,
    output logic             last_fault_valid
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   vec_q, vec_d;
    logic [WIDTH-1:0]   dut_a_q, dut_a_d;
    logic               osc_en_q, osc_en_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic               stop_pending_q, stop_pending_d;
    logic               sync1_q, q_s;
    logic               fault_pulse_q, fault_pulse_d;
    logic [CNT_W-1:0]   fault_count_q, fault_count_d;
    logic [CNT_W-1:0]   sweep_count_q, sweep_count_d;
    logic [WIDTH-1:0]   last_fault_vec_q, last_fault_vec_d;
    logic               last_fault_q_q, last_fault_q_d;
    logic               last_fault_valid_q, last_fault_valid_d;

    logic               exp_par;
    logic               mismatch;
    logic [WIDTH-1:0]   vec_inc;

    assign exp_par  = ^dut_a_q;
    assign mismatch = (q_s != exp_par);
    assign vec_inc  = vec_q + WIDTH'(1);

    always_comb begin
        state_d            = state_q;
        vec_d              = vec_q;
        dut_a_d            = dut_a_q;
        osc_en_d           = 1'b0;
        settle_cnt_d       = settle_cnt_q;
        stop_pending_d     = stop_pending_q;
        fault_pulse_d      = 1'b0;
        fault_count_d      = fault_count_q;
        sweep_count_d      = sweep_count_q;
        last_fault_vec_d   = last_fault_vec_q;
        last_fault_q_d     = last_fault_q_q;
        last_fault_valid_d = last_fault_valid_q;

        case (state_q)
            IDLE: begin
                osc_en_d = locate;
                dut_a_d  = '0;
                // start has priority over stop and locate in IDLE
                if (start) begin
                    state_d        = SETTLE;
                    dut_a_d        = clear ? '0 : vec_q;
                    osc_en_d       = 1'b0;
                    settle_cnt_d   = '0;
                    stop_pending_d = 1'b0;
                end
            end

            SETTLE: begin
                settle_cnt_d = settle_cnt_q + SET_W'(1);
                if (stop) begin
                    stop_pending_d = 1'b1;
                end
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                if (mismatch) begin
                    fault_pulse_d      = 1'b1;
                    fault_count_d      = sat_inc(fault_count_q);
                    last_fault_vec_d   = dut_a_q;
                    last_fault_q_d     = q_s;
                    last_fault_valid_d = 1'b1;
                end
                vec_d = vec_inc;
                // Wrap from all-ones back to zero marks a completed sweep
                if (vec_q == {WIDTH{1'b1}}) begin
                    sweep_count_d = sat_inc(sweep_count_q);
                end
                if (stop_pending_q || stop) begin
                    state_d        = IDLE;
                    dut_a_d        = '0;
                    stop_pending_d = 1'b0;
                end else begin
                    state_d      = SETTLE;
                    dut_a_d      = clear ? '0 : vec_inc;
                    settle_cnt_d = '0;
                end
            end

            default: begin
                state_d = IDLE;
                dut_a_d = '0;
            end
        endcase

        // clear overrides any same-cycle count/capture update, but not the pulse
        if (clear) begin
            vec_d              = '0;
            fault_count_d      = '0;
            sweep_count_d      = '0;
            last_fault_vec_d   = '0;
            last_fault_q_d     = 1'b0;
            last_fault_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            vec_q              <= '0;
            dut_a_q            <= '0;
            osc_en_q           <= 1'b0;
            settle_cnt_q       <= '0;
            stop_pending_q     <= 1'b0;
            sync1_q            <= 1'b0;
            q_s                <= 1'b0;
            fault_pulse_q      <= 1'b0;
            fault_count_q      <= '0;
            sweep_count_q      <= '0;
            last_fault_vec_q   <= '0;
            last_fault_q_q     <= 1'b0;
            last_fault_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            vec_q              <= vec_d;
            dut_a_q            <= dut_a_d;
            osc_en_q           <= osc_en_d;
            settle_cnt_q       <= settle_cnt_d;
            stop_pending_q     <= stop_pending_d;
            // Two-flop synchronizer on the asynchronous target output
            sync1_q            <= dut_q;
            q_s                <= sync1_q;
            fault_pulse_q      <= fault_pulse_d;
            fault_count_q      <= fault_count_d;
            sweep_count_q      <= sweep_count_d;
            last_fault_vec_q   <= last_fault_vec_d;
            last_fault_q_q     <= last_fault_q_d;
            last_fault_valid_q <= last_fault_valid_d;
        end
    end

    assign dut_a            = dut_a_q;
    assign dut_osc_en       = osc_en_q;
    assign busy             = (state_q == SETTLE) || (state_q == SAMPLE);
    assign fault_pulse      = fault_pulse_q;
    assign fault_count      = fault_count_q;
    assign sweep_count      = sweep_count_q;
    assign last_fault_vec   = last_fault_vec_q;
    assign last_fault_q     = last_fault_q_q;
    assign last_fault_valid = last_fault_valid_q;

endmodule

// File: tb/tb_xor_fault_monitor.sv
// ---------------------------------------------------------------------------
// tb_xor_fault_monitor
//
// Directed bench for xor_fault_monitor. A behavioural XOR target model drives
// dut_q from dut_a, optionally with a fault injected on selected vectors.
// The monitor is built with 4-bit counters so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_xor_fault_monitor;

    localparam int WIDTH = 6;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, locate, clear;
    logic [WIDTH-1:0] dut_a;
    logic             dut_osc_en;
    logic             dut_q;
    logic             busy, fault_pulse;
    logic [CNT_W-1:0] fault_count, sweep_count;
    logic [WIDTH-1:0] last_fault_vec;
    logic             last_fault_q, last_fault_valid;

    // Target model: 0 clean, 1 fault at 6'h2A, 2 every vector, 3 fault at 6'h05
    logic [1:0]       mode;
    logic             flip;
    assign flip  = (mode == 2'd1 && dut_a == 6'h2A) || (mode == 2'd2) ||
                   (mode == 2'd3 && dut_a == 6'h05);
    assign dut_q = (^dut_a) ^ flip;

    int vecs = 0;
    int errs = 0;
    int pulse_cnt;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           pulse_cnt <= 0;
        else if (fault_pulse) pulse_cnt <= pulse_cnt + 1;
    end

    xor_fault_monitor #(.WIDTH(WIDTH), .SETTLE_CYCLES(4), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .locate(locate),
        .clear(clear), .dut_a(dut_a), .dut_osc_en(dut_osc_en), .dut_q(dut_q),
        .busy(busy), .fault_pulse(fault_pulse), .fault_count(fault_count),
        .sweep_count(sweep_count), .last_fault_vec(last_fault_vec),
        .last_fault_q(last_fault_q), .last_fault_valid(last_fault_valid)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        locate = 1'b0;
        clear  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Stop a running sweep and wait (bounded) for IDLE
    task automatic stop_sweep();
        int n;
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL stop_timeout: busy=%b want 0", busy);
        end
    endtask

    task automatic wait_vec(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        while (dut_a !== v && n < 600) begin
            tick();
            n++;
        end
        vecs++;
        if (dut_a !== v) begin
            errs++;
            $display("FAIL wait_vec: dut_a=%h want %h", dut_a, v);
        end
    endtask

    task automatic test_reset();
        mode = 2'd0;
        do_reset();
        vecs++;
        if ({dut_a, dut_osc_en, busy, fault_pulse} !== '0) begin
            errs++;
            $display("FAIL reset_ctrl: a=%h osc=%b busy=%b pulse=%b want 0",
                     dut_a, dut_osc_en, busy, fault_pulse);
        end
        vecs++;
        if ({fault_count, sweep_count, last_fault_vec, last_fault_q, last_fault_valid} !== '0) begin
            errs++;
            $display("FAIL reset_cnt: fc=%h sc=%h lv=%h lq=%b lval=%b want 0",
                     fault_count, sweep_count, last_fault_vec, last_fault_q, last_fault_valid);
        end
    endtask

    task automatic test_clean_sweep();
        mode = 2'd0;
        do_reset();
        start = 1'b1;
        repeat (320) tick();
        vecs++;
        if (sweep_count !== 4'd0) begin
            errs++;
            $display("FAIL sweep_early: sweep_count=%0d want 0", sweep_count);
        end
        tick();
        vecs++;
        if (sweep_count !== 4'd1) begin
            errs++;
            $display("FAIL sweep_done: sweep_count=%0d want 1", sweep_count);
        end
        repeat (9) tick();
        vecs++;
        if (sweep_count !== 4'd1 || fault_count !== 4'd0 || last_fault_valid !== 1'b0) begin
            errs++;
            $display("FAIL clean_counts: sc=%0d fc=%0d val=%b want 1 0 0",
                     sweep_count, fault_count, last_fault_valid);
        end
        vecs++;
        if (pulse_cnt !== 0) begin
            errs++;
            $display("FAIL clean_pulses: got %0d want 0", pulse_cnt);
        end
        stop_sweep();
    endtask

    task automatic test_single_fault();
        mode = 2'd1;
        do_reset();
        start = 1'b1;
        repeat (322) tick();
        vecs++;
        if (fault_count !== 4'd1 || last_fault_valid !== 1'b1) begin
            errs++;
            $display("FAIL single_count: fc=%0d val=%b want 1 1", fault_count, last_fault_valid);
        end
        vecs++;
        if (last_fault_vec !== 6'h2A || last_fault_q !== 1'b0) begin
            errs++;
            $display("FAIL single_capture: vec=%h q=%b want 2a 0", last_fault_vec, last_fault_q);
        end
        vecs++;
        if (pulse_cnt !== 1) begin
            errs++;
            $display("FAIL single_pulses: got %0d want 1", pulse_cnt);
        end
        stop_sweep();
    endtask

    task automatic test_stop();
        mode = 2'd3;
        do_reset();
        start = 1'b1;
        wait_vec(6'h05);
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        repeat (3) tick();
        vecs++;
        if (busy !== 1'b1 || dut_a !== 6'h05) begin
            errs++;
            $display("FAIL stop_hold: busy=%b a=%h want 1 05", busy, dut_a);
        end
        tick();
        vecs++;
        if (busy !== 1'b0 || dut_a !== 6'h00) begin
            errs++;
            $display("FAIL stop_idle: busy=%b a=%h want 0 00", busy, dut_a);
        end
        vecs++;
        if (fault_count !== 4'd1 || last_fault_vec !== 6'h05) begin
            errs++;
            $display("FAIL stop_sampled: fc=%0d vec=%h want 1 05", fault_count, last_fault_vec);
        end
        start = 1'b1;
        tick();
        vecs++;
        if (dut_a !== 6'h06 || busy !== 1'b1) begin
            errs++;
            $display("FAIL stop_resume: a=%h busy=%b want 06 1", dut_a, busy);
        end
        stop_sweep();
    endtask

    task automatic test_locate();
        mode = 2'd0;
        do_reset();
        locate = 1'b1;
        vecs++;
        if (dut_osc_en !== 1'b0) begin
            errs++;
            $display("FAIL locate_lat: osc=%b want 0", dut_osc_en);
        end
        tick();
        vecs++;
        if (dut_osc_en !== 1'b1) begin
            errs++;
            $display("FAIL locate_on: osc=%b want 1", dut_osc_en);
        end
        start = 1'b1;
        tick();
        vecs++;
        if (dut_osc_en !== 1'b0 || busy !== 1'b1 || dut_a !== 6'h00) begin
            errs++;
            $display("FAIL locate_start: osc=%b busy=%b a=%h want 0 1 00",
                     dut_osc_en, busy, dut_a);
        end
        repeat (7) tick();
        vecs++;
        if (dut_osc_en !== 1'b0) begin
            errs++;
            $display("FAIL locate_ignored: osc=%b want 0", dut_osc_en);
        end
        locate = 1'b0;
        stop_sweep();
    endtask

    task automatic test_saturate_clear();
        mode = 2'd2;
        do_reset();
        start = 1'b1;
        repeat (75) tick();
        vecs++;
        if (fault_count !== 4'd14) begin
            errs++;
            $display("FAIL sat_pre: fc=%0d want 14", fault_count);
        end
        tick();
        vecs++;
        if (fault_count !== 4'd15) begin
            errs++;
            $display("FAIL sat_reach: fc=%0d want 15", fault_count);
        end
        repeat (30) tick();
        vecs++;
        if (fault_count !== 4'd15 || last_fault_valid !== 1'b1) begin
            errs++;
            $display("FAIL sat_hold: fc=%0d val=%b want 15 1", fault_count, last_fault_valid);
        end
        stop_sweep();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vecs++;
        if ({fault_count, sweep_count, last_fault_vec, last_fault_q, last_fault_valid} !== '0) begin
            errs++;
            $display("FAIL clear_regs: fc=%h sc=%h lv=%h lq=%b val=%b want 0",
                     fault_count, sweep_count, last_fault_vec, last_fault_q, last_fault_valid);
        end
        start = 1'b1;
        tick();
        vecs++;
        if (dut_a !== 6'h00 || busy !== 1'b1) begin
            errs++;
            $display("FAIL clear_restart: a=%h busy=%b want 00 1", dut_a, busy);
        end
        stop_sweep();
    endtask

    task automatic test_async_reset();
        mode = 2'd2;
        do_reset();
        start = 1'b1;
        wait_vec(6'h10);
        tick();
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({dut_a, dut_osc_en, busy, fault_pulse} !== '0) begin
            errs++;
            $display("FAIL async_ctrl: a=%h osc=%b busy=%b pulse=%b want 0",
                     dut_a, dut_osc_en, busy, fault_pulse);
        end
        vecs++;
        if ({fault_count, sweep_count, last_fault_vec, last_fault_q, last_fault_valid} !== '0) begin
            errs++;
            $display("FAIL async_cnt: fc=%h sc=%h lv=%h lq=%b val=%b want 0",
                     fault_count, sweep_count, last_fault_vec, last_fault_q, last_fault_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        vecs++;
        if (dut_a !== 6'h00 || busy !== 1'b1) begin
            errs++;
            $display("FAIL async_restart: a=%h busy=%b want 00 1", dut_a, busy);
        end
        stop_sweep();
    endtask

    initial begin
        rst_n  = 1'b0;
        mode   = 2'd0;
        start  = 1'b0;
        stop   = 1'b0;
        locate = 1'b0;
        clear  = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_sweep();
        test_single_fault();
        test_stop();
        test_locate();
        test_saturate_clear();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/xor_fault_monitor.md
Name: xor_fault_monitor

Overview:
- Stimulus and checker stage wrapped around the XOR laser target. It drives the target's 6-bit `a` bus and `osc_en`, and consumes its `q` output.
- Sweeps all input vectors repeatedly, waits a settle window per vector, and samples `q` through a synchronizer. Compares the sample against expected parity and counts and captures mismatches (laser-induced faults).
- In locate mode it parks the sweep and asserts `osc_en`, so the target's input toggles with the clock for photon-emission location.

Parameters:
- WIDTH, 6, width of the target input bus `a`.
- SETTLE_CYCLES, 4, clock cycles a vector is held before sampling; must be >= 3 to cover the 2-flop synchronizer.
- CNT_W, 16, width of the fault and sweep counters.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; begin sweeping when in IDLE.
- stop  input  1  pulse or level; finish the current vector, then return to IDLE.
- locate  input  1  when in IDLE, drives `dut_osc_en` high.
- clear  input  1  synchronous clear of counters and capture registers.
- dut_a  output  WIDTH  vector to target `a`.
- dut_osc_en  output  1  to target `osc_en`.
- dut_q  input  1  target `q`; asynchronous to clk, so it is synchronized internally.
- busy  output  1  high in SETTLE or SAMPLE.
- fault_pulse  output  1  one-cycle pulse on each detected mismatch.
- fault_count  output  CNT_W  saturating mismatch count.
- sweep_count  output  CNT_W  saturating count of completed full sweeps.
- last_fault_vec  output  WIDTH  `dut_a` value at the most recent mismatch.
- last_fault_q  output  1  sampled `q` at the most recent mismatch.
- last_fault_valid  output  1  set on the first mismatch since reset or clear.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - dut_a=0, dut_osc_en=0, busy=0, fault_pulse=0.
  - fault_count=0, sweep_count=0, last_fault_vec=0, last_fault_q=0, last_fault_valid=0.
  - Synchronizer flops=0, vector register=0, settle counter=0, stop_pending=0.
- Synchronizer: `dut_q` passes through 2 flops every cycle in all states; `q_s` is the second flop output.
- Expected value: `exp = XOR-reduce(dut_a)`.
- IDLE:
  - dut_osc_en = locate (registered, one-cycle latency); dut_a holds 0; busy=0.
  - start=1 at an edge -> next state SETTLE.
  - On that same edge: dut_a <= vector register, dut_osc_en <= 0, settle counter <= 0, stop_pending <= 0.
  - locate is ignored outside IDLE.
- SETTLE:
  - Settle counter increments each cycle.
  - When settle counter == SETTLE_CYCLES-1 -> SAMPLE.
  - dut_a is stable for the whole window.
- SAMPLE (exactly 1 cycle):
  - Mismatch (q_s != exp): fault_pulse=1 the following cycle; fault_count += 1 (saturates at all-ones); last_fault_vec <= dut_a; last_fault_q <= q_s; last_fault_valid <= 1.
  - Vector register <= vector+1, wrapping at 2^WIDTH.
  - On wrap from all-ones to 0: sweep_count += 1 (saturating).
  - If stop_pending, or stop=1 this cycle -> IDLE, with dut_a <= 0.
  - Otherwise -> SETTLE with dut_a <= new vector and settle counter <= 0.
- Latency: each vector occupies SETTLE_CYCLES+1 cycles (5 at default). A full sweep is 2^WIDTH*(SETTLE_CYCLES+1) cycles (320 at default).
- stop:
  - Asserted in SETTLE: sets stop_pending; the current vector is still sampled, then IDLE.
  - Asserted in IDLE: no effect.
  - The vector register is retained across stop and start, so the sweep resumes at the next vector.
- clear:
  - Zeroes fault_count, sweep_count, last_fault_vec, last_fault_q, last_fault_valid and the vector register.
  - Does not change state.
  - Same-cycle mismatch: clear wins; fault_count=0, but fault_pulse still asserts.
- start and stop both high in IDLE: start wins; stop_pending is not set by that cycle's stop.
- Reset mid-sweep: immediate return to reset values; no partial count update.

Test Plan:
1. Fault-free model (dut_q = ^dut_a), start held 1 for 330 cycles -> first sweep completes at cycle 320; sweep_count=1, fault_count=0, last_fault_valid=0, fault_pulse never high.
2. Model flips q only when a==6'h2A, one sweep -> fault_count=1, last_fault_vec=6'h2A, last_fault_q=0, exactly one fault_pulse.
3. Pulse stop while dut_a==6'h05 is in SETTLE -> 6'h05 is still sampled, then IDLE with dut_a=0. Next start drives 6'h06.
4. IDLE with locate=1 -> dut_osc_en=1 one cycle later. Assert start -> dut_osc_en=0 on the same edge that loads dut_a.
5. Inverted model (every vector faulty) with CNT_W=4 -> fault_count saturates at 15 after 15 vectors and stays 15. Then clear -> all counters and capture registers 0 and the vector restarts at 0.
6. Deassert rst_n mid-SETTLE at vector 6'h10 -> all outputs at reset values asynchronously. After release, start drives dut_a=0.
